// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM states and byte-lane helpers for the MEM stage.
package mem_stage_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   function automatic logic is_memop(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   // Column write enables for a store at byte offset lo.
   function automatic logic [3:0] lane_we(input logic [3:0] op, input logic [1:0] lo);
      case (op)
         OP_SB:   return 4'b0001 << lo;
         OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
         OP_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate narrow store data so every enabled lane sees the right bytes.
   function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic misalign(input logic [3:0] op, input logic [1:0] lo);
      case (op)
         OP_LH, OP_LHU, OP_SH: return lo[0];
         OP_LW, OP_SW:         return lo != 2'd0;
         default:              return 1'b0;
      endcase
   endfunction

   // Pick the addressed byte/half out of the RAM word and extend it.
   function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lo,
                                               input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LW:   return w;
         OP_LBU:  return {24'd0, b};
         OP_LHU:  return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/bytewe_ram.sv
// Single-port word RAM with per-byte write enables, synchronous write-first read.
module bytewe_ram #(
   parameter int NB_DEPTH = 10
) (
   input  logic                i_clk,
   input  logic                i_en,
   input  logic [3:0]          i_we,
   input  logic [NB_DEPTH-1:0] i_addr,
   input  logic [31:0]         i_wdata,
   output logic [31:0]         o_rdata
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] r_mem [0:(1<<NB_DEPTH)-1];
      logic [7:0] r_q;

      // One byte column: written lanes return the new byte on the same edge.
      always_ff @(posedge i_clk) begin
         if (i_en) begin
            if (i_we[l]) begin
               r_mem[i_addr] <= i_wdata[l*8 +: 8];
               r_q           <= i_wdata[l*8 +: 8];
            end else begin
               r_q <= r_mem[i_addr];
            end
         end
      end

      assign o_rdata[l*8 +: 8] = r_q;
   end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte-lane loads/stores, wait-state stall, misalign flag, debug read.
module mem_access_stage #(
   parameter int NB_BITS  = 32,
   parameter int NB_DEPTH = 10,
   parameter int NB_REG   = 5,
   parameter int NB_WB    = 8,
   parameter int NB_WAIT  = 0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   input  logic [3:0]          i_mem_op,
   input  logic [NB_BITS-1:0]  i_addr,
   input  logic [NB_BITS-1:0]  i_data,
   input  logic [NB_REG-1:0]   i_reg_dst,
   input  logic [NB_WB-1:0]    i_wb_ctl,
   input  logic                i_dbg_en,
   input  logic [NB_DEPTH-1:0] i_dbg_addr,
   output logic                o_stall,
   output logic                o_valid,
   output logic [NB_BITS-1:0]  o_mem_data,
   output logic [NB_BITS-1:0]  o_alu_data,
   output logic [NB_REG-1:0]   o_reg_dst,
   output logic [NB_WB-1:0]    o_wb_ctl,
   output logic                o_misalign,
   output logic [NB_BITS-1:0]  o_dbg_data,
   output logic                o_dbg_ack
);
   import mem_stage_pkg::*;

   logic [1:0]          w_lo;
   logic                w_memop, w_mis, w_stall, w_adv, w_go, w_dbg_go;
   logic                w_ram_en;
   logic [3:0]          w_ram_we;
   logic [NB_DEPTH-1:0] w_ram_addr;
   logic [31:0]         w_rdata;
   logic                w_unused_addr;

   logic                r_valid, r_mis, r_ld, r_dbg_ack;
   logic [3:0]          r_op;
   logic [1:0]          r_lo;
   logic [NB_BITS-1:0]  r_alu;
   logic [NB_REG-1:0]   r_reg_dst;
   logic [NB_WB-1:0]    r_wb;

   assign w_lo          = i_addr[1:0];
   assign w_memop       = i_valid & is_memop(i_mem_op);
   assign w_mis         = w_memop & misalign(i_mem_op, w_lo);
   // Address bits above the RAM index are deliberately dropped (wrap modulo depth).
   assign w_unused_addr = ^i_addr[NB_BITS-1:NB_DEPTH+2];

   if (NB_WAIT > 0) begin : g_fsm
      state_t     r_state;
      logic [2:0] r_cnt;

      // Wait-state sequencer: IDLE->WAIT on a mem op, release after NB_WAIT counts.
      always_ff @(posedge i_clk or negedge i_rst) begin
         if (!i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
         end else begin
            case (r_state)
               ST_IDLE: if (w_memop) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= 3'd1;
               end
               ST_WAIT: if (r_cnt < 3'(NB_WAIT)) begin
                  r_cnt <= r_cnt + 3'd1;
               end else begin
                  r_state <= ST_IDLE;
                  r_cnt   <= 3'd0;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end

      assign w_stall = i_rst & (((r_state == ST_IDLE) & w_memop) |
                                ((r_state == ST_WAIT) & (r_cnt < 3'(NB_WAIT))));
   end else begin : g_nofsm
      assign w_stall = 1'b0;
   end

   // Access happens only out of reset with the stall released; debug steals idle cycles.
   assign w_adv      = i_valid & ~w_stall;
   assign w_go       = i_rst & w_memop & ~w_stall;
   assign w_dbg_go   = i_rst & i_dbg_en & ~w_memop & ~w_stall;
   assign w_ram_en   = w_go | w_dbg_go;
   assign w_ram_we   = (w_go & ~w_mis & is_store(i_mem_op)) ? lane_we(i_mem_op, w_lo) : 4'b0000;
   assign w_ram_addr = w_dbg_go ? i_dbg_addr : i_addr[NB_DEPTH+1:2];

   bytewe_ram #(.NB_DEPTH(NB_DEPTH)) u_ram (
      .i_clk   (i_clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (store_data(i_mem_op, i_data)),
      .o_rdata (w_rdata)
   );

   // MEM/WB pipeline register; stalls and misaligned ops clear write-back control.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_valid   <= 1'b0;
         r_mis     <= 1'b0;
         r_ld      <= 1'b0;
         r_dbg_ack <= 1'b0;
         r_op      <= OP_NOP;
         r_lo      <= 2'd0;
         r_alu     <= '0;
         r_reg_dst <= '0;
         r_wb      <= '0;
      end else begin
         r_valid   <= w_adv;
         r_mis     <= w_adv & w_mis;
         r_ld      <= w_adv & is_load(i_mem_op) & ~w_mis;
         r_dbg_ack <= w_dbg_go;
         r_op      <= i_mem_op;
         r_lo      <= w_lo;
         r_alu     <= i_addr;
         r_reg_dst <= i_reg_dst;
         r_wb      <= (w_adv & ~w_mis) ? i_wb_ctl : '0;
      end
   end

   assign o_stall    = w_stall;
   assign o_valid    = r_valid;
   assign o_mem_data = r_ld ? load_extend(r_op, r_lo, w_rdata) : '0;
   assign o_alu_data = r_alu;
   assign o_reg_dst  = r_reg_dst;
   assign o_wb_ctl   = r_wb;
   assign o_misalign = r_mis;
   assign o_dbg_data = r_dbg_ack ? w_rdata : '0;
   assign o_dbg_ack  = r_dbg_ack;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage of the MIPS core: performs byte/halfword/word loads and stores on a byte-write-enabled synchronous data RAM, sign/zero-extends load results, and latches the MEM/WB pipeline register. It adds three things the single-width word-only stage lacks:
- configurable wait states with a stall handshake to the hazard unit;
- misalignment detection;
- a debug read port for the debug unit.

## Interface
Parameters:
- NB_BITS, 32, data/address width (fixed 32 for byte-lane logic; 4 lanes)
- NB_DEPTH, 10, log2 of RAM depth in words
- NB_REG, 5, destination register index width
- NB_WB, 8, write-back control width
- NB_WAIT, 0, extra wait cycles per memory access (0..7)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  instruction in MEM is valid
- i_mem_op  in  4  memory operation (encoding in package)
- i_addr  in  NB_BITS  ALU result / effective address
- i_data  in  NB_BITS  store data (rt)
- i_reg_dst  in  NB_REG  destination register
- i_wb_ctl  in  NB_WB  write-back control
- i_dbg_en  in  1  debug word-read request
- i_dbg_addr  in  NB_DEPTH  debug word index
- o_stall  out  1  hold upstream stages (combinational)
- o_valid  out  1  registered valid to WB
- o_mem_data  out  NB_BITS  extended load data
- o_alu_data  out  NB_BITS  registered i_addr
- o_reg_dst  out  NB_REG  registered destination
- o_wb_ctl  out  NB_WB  registered WB control (zeroed on bubble/misalign)
- o_misalign  out  1  registered per-op misalignment flag
- o_dbg_data  out  NB_BITS  debug read word
- o_dbg_ack  out  1  one-cycle pulse, o_dbg_data valid

## Operation
- Op codes: 0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NOP.
- "Mem op" means i_valid and a code in 1..8.
- Word index: i_addr[NB_DEPTH+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Lanes are little-endian: addr[1:0]=0 selects bits [7:0].
- Store write enables and data:
  - SB: we = 1<<addr[1:0], data {4{i_data[7:0]}}.
  - SH: we = addr[1] ? 4'b1100 : 4'b0011, data {2{i_data[15:0]}}.
  - SW: we = 4'b1111.
- Load extraction uses the registered op and addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. On a misaligned op:
  - the write is suppressed;
  - o_mem_data=0, o_wb_ctl=0, o_misalign=1.
- Non-mem ops pass i_addr/i_reg_dst/i_wb_ctl straight through the register; o_mem_data=0.
- Debug port: a debug read is served only in a cycle with no mem op and no stall. Otherwise the request is ignored and the debug unit retries.

FSM (only when NB_WAIT>0):
- IDLE: a mem op arrives → go to WAIT, cnt=1, o_stall=1.
- WAIT: cnt<NB_WAIT → cnt++, o_stall=1. cnt==NB_WAIT → o_stall=0, the RAM access happens this cycle, go to IDLE.
- While o_stall=1 the pipeline register loads a bubble (o_valid=0, o_wb_ctl=0). Upstream must hold its inputs stable.
- Non-mem ops never stall.
- With NB_WAIT=0 the FSM is absent and o_stall is tied 0.

## Timing
- Reset (i_rst=0, asynchronous): every output is 0, FSM=IDLE, cnt=0. RAM contents are not reset.
- Reset during WAIT aborts the access; the pending store is not written.
- Access cycle T (stall low):
  - RAM read/write at edge T+1;
  - o_mem_data, o_alu_data, o_reg_dst, o_wb_ctl, o_valid, o_misalign all valid after edge T+1 (latency 1).
- Total latency of a mem op is NB_WAIT+1 cycles.
- Store then load to the same word in consecutive cycles: the load returns the new data (write-first RAM).
- Debug request at cycle T → o_dbg_data and o_dbg_ack=1 after edge T+1, for one cycle.

## Structure
- Package mem_stage_pkg:
  - op code localparams;
  - lane-enable function;
  - misalign function;
  - load-extend function.
- Sub-module bytewe_ram:
  - single port, NB_DEPTH address, 4×8 column write enables;
  - synchronous read, write-first;
  - the debug read is muxed onto the same port.
- Top module contains:
  - FSM + counter;
  - pipeline register;
  - extraction logic.

## Test plan
- SW 0xDEADBEEF @0x10, then LB @0x13, LBU @0x13, LH @0x12, LHU @0x12 → 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- SB 0x7F @0x21, then LW @0x20 (word preset 0) → 0x00007F00; only lane 1 is written.
- LW @0x22 → o_misalign=1, o_wb_ctl=0, o_mem_data=0. SH @0x23 → RAM word unchanged.
- NB_WAIT=3, LW → o_stall high 3 cycles, bubbles on o_valid, data on the 4th edge. A NOP issued meanwhile is held, with no stall of its own.
- Debug read of word 4 while the pipeline issues NOPs → o_dbg_ack pulse with the correct word. Concurrent LW → request ignored, no ack.
- Drop i_rst mid-WAIT of an SW → all outputs 0 immediately, target word unchanged, FSM=IDLE after release.
